// File: rtl/hit_encoder16.sv
// hit_encoder16: captures a 16-bit multi-hot line-hit vector and streams out
// the 4-bit index of every set line, one beat per cycle, on a valid/ready port.
// This is the inverse of the array's 4-to-16 row/column decoder.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   in_valid     in_vec is valid this cycle
//   in_ready     block is idle and will capture in_vec on in_valid
//   in_vec       multi-hot hit vector, bit i = line i hit
//   out_valid    out_addr holds a valid encoded index
//   out_ready    downstream accepts the current beat
//   out_addr     encoded index of the current hit line
//   out_last     current beat is the final hit of the frame
//   out_count    popcount of the last captured vector (0..16)
//   frame_empty  one-cycle pulse after capturing an all-zero vector
//
// Parameter LSB_FIRST: 1 = emit lowest set index first, 0 = highest first.
module hit_encoder16 #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [15:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_addr,
    output logic       out_last,
    output logic [4:0] out_count,
    output logic       frame_empty
);

    localparam int unsigned VEC_W  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [VEC_W-1:0]   pending, pending_n;
    logic [VEC_W-1:0]   remaining;
    logic               in_ready_n;
    logic               out_valid_n;
    logic [ADDR_W-1:0]  out_addr_n;
    logic               out_last_n;
    logic [CNT_W-1:0]   out_count_n;
    logic               frame_empty_n;

    // Index of the first set bit in emit order; don't-care for v == 0.
    function automatic logic [ADDR_W-1:0] pick_index(input logic [VEC_W-1:0] v);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        if (LSB_FIRST != 0) begin
            for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
                if (v[i]) idx = ADDR_W'(i);
            end
        end else begin
            for (int i = 0; i < int'(VEC_W); i++) begin
                if (v[i]) idx = ADDR_W'(i);
            end
        end
        return idx;
    endfunction

    // Number of set bits, 0..16.
    function automatic logic [CNT_W-1:0] pop_count(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(VEC_W); i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_last    <= 1'b0;
            out_count   <= '0;
            frame_empty <= 1'b0;
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            in_ready    <= in_ready_n;
            out_valid   <= out_valid_n;
            out_addr    <= out_addr_n;
            out_last    <= out_last_n;
            out_count   <= out_count_n;
            frame_empty <= frame_empty_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        pending_n     = pending;
        in_ready_n    = in_ready;
        out_valid_n   = out_valid;
        out_addr_n    = out_addr;
        out_last_n    = out_last;
        out_count_n   = out_count;
        frame_empty_n = 1'b0;
        // Hits left once the beat currently on out_addr is taken.
        remaining     = pending & ~(VEC_W'(1) << out_addr);

        unique case (state)
            IDLE: begin
                // in_vec is only looked at on an actual capture.
                if (in_valid) begin
                    pending_n   = in_vec;
                    out_count_n = pop_count(in_vec);
                    if (in_vec != '0) begin
                        state_n     = EMIT;
                        in_ready_n  = 1'b0;
                        out_valid_n = 1'b1;
                        out_addr_n  = pick_index(in_vec);
                        out_last_n  = (pop_count(in_vec) == CNT_W'(1));
                    end else begin
                        frame_empty_n = 1'b1;
                    end
                end
            end
            EMIT: begin
                // Without out_ready everything holds.
                if (out_ready) begin
                    pending_n = remaining;
                    if (remaining != '0) begin
                        out_addr_n = pick_index(remaining);
                        out_last_n = (pop_count(remaining) == CNT_W'(1));
                    end else begin
                        state_n     = IDLE;
                        in_ready_n  = 1'b1;
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/hit_encoder16.md
Name: hit_encoder16

Overview:
Reverse of the array's 4-to-16 row/column decoder. It captures a 16-bit multi-hot line vector (row or column hit flags from the nanocmos array) and emits the 4-bit index of each set line, one per cycle. Output uses a valid/ready stream with a last-of-frame marker and a hit count. It sits between array readout and the address/event FIFO, so decoded-line addresses can be round-tripped back through the decoder.

Parameters:
LSB_FIRST, 1, emit order: 1 = lowest set index first, 0 = highest set index first

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_vec is valid this cycle
in_ready  output  1  block is idle and can capture a new vector
in_vec  input  16  multi-hot line-hit vector; bit i = line i hit
out_valid  output  1  out_addr holds a valid encoded index
out_ready  input  1  downstream accepts the current index
out_addr  output  4  encoded index of the current hit line
out_last  output  1  current beat is the final hit of the frame
out_count  output  5  popcount of the captured vector (0..16)
frame_empty  output  1  one-cycle pulse when an all-zero vector is captured

Behaviour:
- States: IDLE, EMIT. Register `pending[15:0]` holds the hits not yet emitted.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, pending=0.
  - out_valid=0, out_addr=0, out_last=0, out_count=0, frame_empty=0.
  - in_ready = (state==IDLE), so it reads 1. No capture happens while reset is high.
- Capture: on a rising edge with in_valid & in_ready:
  - pending <= in_vec and out_count <= popcount(in_vec).
  - in_vec is ignored whenever in_ready=0.
- IDLE, captured in_vec != 0 -> EMIT. Next cycle:
  - out_valid=1, in_ready=0.
  - out_addr = lowest set index (LSB_FIRST=1) or highest set index (LSB_FIRST=0) of pending.
  - out_last = 1 iff exactly one bit of pending is set.
  - Capture-to-first-beat latency is one cycle.
- IDLE, captured in_vec == 0:
  - Stay in IDLE and pulse frame_empty high for exactly one cycle.
  - in_ready stays 1 and out_valid stays 0; out_count becomes 0.
- EMIT, out_valid & !out_ready: out_addr, out_last and pending hold stable (no drop, no change).
- EMIT, out_valid & out_ready:
  - Clear the emitted bit in pending.
  - If bits remain: the next index is presented on the following cycle with out_valid held high (throughput one beat per cycle).
  - If that was the last bit: go to IDLE; next cycle out_valid=0, out_last=0, in_ready=1.
  - out_addr keeps its last value while idle.
- out_count holds until the next capture, including an all-zero capture.
- No capture is possible during EMIT. A back-to-back frame gets at best one idle cycle between the last beat of one frame and the first beat of the next.
- Reset mid-frame: remaining hits are discarded and outputs return to reset values immediately. After deassertion the block is in IDLE with in_ready=1.
- Width rules:
  - out_count is 5 bits so 16 hits is representable (5'd16).
  - Index arithmetic is exact over 0..15 with no wrap.
- No X-propagation from in_vec while not capturing.

Test Plan:
1. Reset then capture 16'h0020, out_ready=1 -> next cycle out_valid=1, out_addr=5, out_last=1, out_count=5'd1; following cycle out_valid=0, in_ready=1.
2. Capture 16'h8001, LSB_FIRST=1, out_ready=1 -> out_addr=0 (last=0) then out_addr=15 (last=1) on consecutive cycles, out_count=2. Repeat with LSB_FIRST=0 -> order 15 then 0.
3. Capture 16'h00C0, out_ready=0 for 3 cycles then 1 -> out_addr=6 held stable for 4 cycles, then 7 with last=1. Assert in_valid with 16'hFFFF throughout and check it is not captured (in_ready=0).
4. Capture 16'h0000 -> frame_empty high exactly one cycle, out_valid never rises, out_count=0, in_ready stays 1.
5. Capture 16'hFFFF, out_ready=1 -> 16 beats with addr 0..15, last only on 15, out_count=5'd16. Assert reset after beat 7 -> out_valid drops immediately; after release, in_ready=1 and no stale beats are emitted.
6. Round-trip: for each addr 0..15, drive the 4-to-16 decoder with addr and feed its one-hot output into in_vec -> the single beat returns out_addr==addr with last=1.
